// File: rtl/tnn_pkg.sv
// Shared types for the ternary neuron: weight encoding, FSM states and the
// accumulator width rule.
package tnn_pkg;

   typedef enum logic [1:0] {
      WT_ZERO = 2'b00,
      WT_POS  = 2'b01,
      WT_RSV  = 2'b10,
      WT_NEG  = 2'b11
   } wt_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ACCUM = 2'b01,
      S_HOLD  = 2'b10
   } state_e;

   // Signed accumulator width: one sign bit plus headroom for n_in unsigned operands.
   function automatic int unsigned tnn_aw(input int unsigned w, input int unsigned n_in);
      return w + $clog2(n_in) + 1;
   endfunction

endpackage

// File: rtl/tnn_term.sv
// Ternary multiply of one unsigned operand by a {+1,0,-1} weight.
// TNN_APPROX_EN zeroes APPROX_LSB operand LSBs before the multiply.
module tnn_term
   import tnn_pkg::*;
#(
   parameter int unsigned W          = 3,
   parameter int unsigned AW         = 6,
   parameter int unsigned APPROX_LSB = 1
) (
   input  logic [W-1:0]         data,
   input  logic [1:0]           wt,
   output logic signed [AW-1:0] term_c
);

`ifdef TNN_APPROX_EN
   localparam bit APPROX_ON = 1'b1;
`else
   localparam bit APPROX_ON = 1'b0;
`endif

   localparam int unsigned TRUNC_LSB = APPROX_ON ? APPROX_LSB : 0;
   localparam logic [W-1:0] OP_MASK  = ~((W'(1) << TRUNC_LSB) - W'(1));

   logic [W-1:0]         op;
   logic signed [AW-1:0] mag;

   assign op  = data & OP_MASK;
   assign mag = signed'(AW'(op));

   // Reserved weight code behaves as zero.
   always_comb begin
      term_c = '0;
      case (wt)
         WT_POS:  term_c = mag;
         WT_NEG:  term_c = -mag;
         default: term_c = '0;
      endcase
   end

endmodule

// File: rtl/tnn_neuron_seq.sv
// Sequential ternary neuron: accumulates weighted operand beats of one sample
// and emits a registered threshold decision. Build option: TNN_APPROX_EN.
module tnn_neuron_seq
   import tnn_pkg::*;
#(
   parameter int unsigned W          = 3,
   parameter int unsigned N_IN       = 3,
   parameter int unsigned APPROX_LSB = 1,
   localparam int unsigned AW        = tnn_aw(W, N_IN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [1:0]    in_wt,
   input  logic          in_last,
   input  logic [AW-1:0] in_thr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_err
);

   localparam int unsigned CW = $clog2(N_IN + 1);

   state_e               state, state_d;
   logic signed [AW-1:0] acc, acc_d;
   logic signed [AW-1:0] thr, thr_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic                 err, err_d;
   logic                 out_valid_d, out_bit_d, out_err_d;
   logic signed [AW-1:0] term_c;
   logic                 beat, out_hs, first_beat;

   tnn_term #(
      .W          (W),
      .AW         (AW),
      .APPROX_LSB (APPROX_LSB)
   ) u_term (
      .data   (in_data),
      .wt     (in_wt),
      .term_c (term_c)
   );

   assign in_ready   = !out_valid || out_ready;
   assign beat       = in_valid && in_ready;
   assign out_hs     = out_valid && out_ready;
   // A beat outside ACCUM always opens a new sample, including one that
   // coincides with the result handshake in HOLD.
   assign first_beat = (state != S_ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         thr       <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         thr       <= thr_d;
         cnt       <= cnt_d;
         err       <= err_d;
         out_valid <= out_valid_d;
         out_bit   <= out_bit_d;
         out_err   <= out_err_d;
      end
   end

   always_comb begin
      state_d     = state;
      acc_d       = acc;
      thr_d       = thr;
      cnt_d       = cnt;
      err_d       = err;
      out_valid_d = out_valid;
      out_bit_d   = out_bit;
      out_err_d   = out_err;

      if (out_hs) begin
         out_valid_d = 1'b0;
         state_d     = S_IDLE;
      end

      if (beat) begin
         if (first_beat) begin
            acc_d = term_c;
            thr_d = signed'(in_thr);
            cnt_d = CW'(1);
            err_d = 1'b0;
         end else if (cnt < CW'(N_IN)) begin
            acc_d = acc + term_c;
            cnt_d = cnt + CW'(1);
         end else begin
            err_d = 1'b1;
         end

         if (in_last) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            out_bit_d   = (acc_d >= thr_d);
            out_err_d   = err_d;
         end else begin
            state_d = S_ACCUM;
         end
      end
   end

endmodule

// File: doc/tnn_neuron_seq.md
TNN_NEURON_SEQ -- requirements
Module: tnn_neuron_seq

Interface
REQ-001 SHALL provide parameter W, default 3, operand width in bits (unsigned).
REQ-002 SHALL provide parameter N_IN, default 3, maximum operands per sample.
REQ-003 SHALL provide parameter APPROX_LSB, default 1, operand LSBs zeroed when approximation is compiled in (0 <= APPROX_LSB < W).
REQ-004 SHALL derive localparam AW = W + $clog2(N_IN) + 1, signed accumulator width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  operand beat valid.
REQ-009 in_ready  output  1  operand beat accepted when high with in_valid.
REQ-010 in_data  input  W  unsigned operand.
REQ-011 in_wt  input  2  ternary weight: 01=+1, 11=-1, 00=0, 10=0 (reserved).
REQ-012 in_last  input  1  final beat of sample.
REQ-013 in_thr  input  AW  signed threshold, sampled on first beat of a sample.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  result consumed when high with out_valid.
REQ-016 out_bit  output  1  neuron decision.
REQ-017 out_err  output  1  sample exceeded N_IN beats.

Function
REQ-018 Term = +op, -op or 0 per in_wt; op = in_data (exact) or in_data with APPROX_LSB LSBs zeroed (approx build).
REQ-019 States SHALL be IDLE (no beat yet), ACCUM (beats accepted, no in_last), HOLD (out_valid high); IDLE->ACCUM on accepted non-last beat; IDLE/ACCUM->HOLD on accepted in_last; HOLD->IDLE on out handshake without a concurrent beat.
REQ-020 First beat SHALL load acc = term and thr = in_thr; later beats SHALL add term to acc.
REQ-021 out_bit SHALL equal (acc_final >= thr) as signed compare, registered, out_valid asserted the cycle after the in_last beat is accepted (latency 1).
REQ-022 in_ready SHALL equal !out_valid | out_ready.
REQ-023 out_valid, out_bit and out_err SHALL hold stable until out handshake.
REQ-024 Beat accepted in the same cycle as out handshake SHALL start a new sample (acc reloaded, not accumulated).
REQ-025 Beat counter SHALL saturate at N_IN; beats beyond N_IN SHALL be ignored for acc and set out_err for that sample.
REQ-026 Single-beat sample (in_last on first beat) SHALL be legal.
REQ-027 Accumulator SHALL never overflow within N_IN beats (guaranteed by AW).

Reset
REQ-028 rst_n low SHALL force IDLE, acc=0, thr=0, count=0, out_valid=0, out_bit=0, out_err=0 immediately.
REQ-029 Reset mid-sample SHALL discard the partial sample; in_ready SHALL read 1 after reset.

Configuration
REQ-030 Macro TNN_APPROX_EN defined: operand truncation per REQ-018 active; undefined: exact operands, APPROX_LSB ignored.

Structure
REQ-031 Shared package tnn_pkg SHALL hold the weight encoding enum, the AW width function and the state typedef.
REQ-032 Sub-module tnn_term (combinational ternary multiply plus optional truncation) SHALL compute each term.

Verification
REQ-033 Exact build, W=3,N_IN=3: beats 5,5,5 wt +1, thr=15 -> out_bit=1, out_err=0, out_valid 1 cycle after last.
REQ-034 TNN_APPROX_EN, APPROX_LSB=1: same stimulus -> terms 4,4,4, sum 12 -> out_bit=0.
REQ-035 Weights +1,-1,0 on 7,6,3, thr=1 -> sum 1 -> out_bit=1; thr=2 -> out_bit=0.
REQ-036 out_ready held low 4 cycles with next sample pending -> in_ready=0, result stable; release -> new first beat accepted same cycle, acc reloaded.
REQ-037 Five beats of 1 (+1), in_last on fifth, thr=3 -> out_err=1, acc uses first 3 beats, out_bit=1.
REQ-038 rst_n pulsed low after second beat -> no out_valid; subsequent sample 2,2 thr=4 -> out_bit=1.
